store_drain_unit: RTL and testbench

Downstream of the store buffer: accepts committed store requests from the SB head and converts each one into a word-aligned L1 D-cache write. The conversion produces a byte strobe and lane-replicated data. The unit keeps up to OUTSTANDING writes in flight, checks alignment, and reports misaligned or bus-error faults. It also provides an `idle_o` flag that fence/ecall logic uses to wait for the memory system to drain.

---
 rtl/config_pkg.sv | 11 +
 rtl/decode_pkg.sv | 15 +
 rtl/store_drain_unit_pkg.sv | 26 ++
 rtl/sdu_addr_fifo.sv | 68 ++++++
 rtl/store_drain_unit.sv | 155 +++++++++++++++
 tb/tb_store_drain_unit.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/config_pkg.sv
// Core-wide configuration: physical address and data word widths.
package config_pkg;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned XLEN;
  } cfg_t;

  localparam cfg_t Cfg = '{PLEN: 32, XLEN: 32};

endpackage

// File: rtl/decode_pkg.sv
// Decoder-side definitions shared with the load/store path.
package decode_pkg;

  typedef enum logic [3:0] {
    LSU_LB,
    LSU_LBU,
    LSU_LH,
    LSU_LHU,
    LSU_LW,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_op_e;

endpackage

// File: rtl/store_drain_unit_pkg.sv
// Types and widths for the store drain unit.
package store_drain_unit_pkg;
  import config_pkg::*;

  localparam int unsigned SDU_PLEN  = Cfg.PLEN;
  localparam int unsigned SDU_XLEN  = Cfg.XLEN;
  localparam int unsigned SDU_BE_W  = SDU_XLEN / 8;
  localparam int unsigned SDU_OFF_W = $clog2(SDU_BE_W);

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUSERR   = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } sdu_cause_e;

  // The stage keeps the original byte address; alignment is applied on output.
  typedef struct packed {
    logic                valid;
    logic [SDU_PLEN-1:0] addr;
    logic [SDU_XLEN-1:0] wdata;
    logic [SDU_BE_W-1:0] be;
    sdu_cause_e          cause;
  } sdu_stage_t;

endpackage

// File: rtl/sdu_addr_fifo.sv
// Small synchronous FIFO tracking byte addresses of writes awaiting ack.
module sdu_addr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/store_drain_unit.sv
// Turns committed stores into word-aligned D-cache writes and reports faults.
module store_drain_unit
  import decode_pkg::*;
  import store_drain_unit_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int OFF_W       = $clog2(SDU_XLEN / 8)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sb_req_valid_i,
  output logic                sb_req_ready_o,
  input  logic [SDU_PLEN-1:0] sb_req_addr_i,
  input  logic [SDU_XLEN-1:0] sb_req_data_i,
  input  lsu_op_e             sb_req_op_i,
  output logic                dc_req_valid_o,
  input  logic                dc_req_ready_i,
  output logic [SDU_PLEN-1:0] dc_req_addr_o,
  output logic [SDU_XLEN-1:0] dc_req_wdata_o,
  output logic [SDU_BE_W-1:0] dc_req_be_o,
  input  logic                dc_rsp_valid_i,
  input  logic                dc_rsp_err_i,
  output logic                fault_valid_o,
  output logic [1:0]          fault_cause_o,
  output logic [SDU_PLEN-1:0] fault_addr_o,
  output logic                idle_o
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  sdu_stage_t          stage_q, stage_d, fmt;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                buserr_q, buserr_d;
  logic [SDU_PLEN-1:0] buserr_addr_q, buserr_addr_d;
  logic [SDU_PLEN-1:0] fifo_head;
  logic                fifo_full, fifo_empty;
  logic [OFF_W-1:0]    off;
  logic                rsp_fire, issue, stage_fault, stage_done, accept;

  // Acks with nothing in flight (e.g. stale ones after reset) are dropped.
  assign rsp_fire    = dc_rsp_valid_i && (cnt_q != '0);
  // A pending bus-error report is older than the stage, so the stage fault waits.
  assign stage_fault = stage_q.valid && (stage_q.cause != CAUSE_NONE) && !buserr_q;

  assign dc_req_valid_o = stage_q.valid && (stage_q.cause == CAUSE_NONE) &&
                          ((cnt_q < CNT_W'(OUTSTANDING)) || dc_rsp_valid_i);
  assign issue          = dc_req_valid_o && dc_req_ready_i;
  assign stage_done     = issue || stage_fault;
  assign sb_req_ready_o = !rst_i && (!stage_q.valid || stage_done);
  assign accept         = sb_req_valid_i && sb_req_ready_o;

  assign dc_req_addr_o  = {stage_q.addr[SDU_PLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign dc_req_wdata_o = stage_q.wdata;
  assign dc_req_be_o    = stage_q.be;
  assign idle_o         = !stage_q.valid && (cnt_q == '0);

  assign off = sb_req_addr_i[OFF_W-1:0];

  // Format the incoming store into strobe, replicated data and fault cause.
  always_comb begin
    fmt       = '0;
    fmt.valid = 1'b1;
    fmt.addr  = sb_req_addr_i;
    fmt.wdata = sb_req_data_i;
    fmt.be    = '1;
    fmt.cause = CAUSE_NONE;
    case (sb_req_op_i)
      LSU_SB: begin
        fmt.be    = SDU_BE_W'(1) << off;
        fmt.wdata = {SDU_BE_W{sb_req_data_i[7:0]}};
      end
      LSU_SH: begin
        fmt.be    = SDU_BE_W'(3) << off;
        fmt.wdata = {(SDU_XLEN / 16){sb_req_data_i[15:0]}};
        if (off[0]) fmt.cause = CAUSE_MISALIGN;
      end
      LSU_SW: begin
        if (off != '0) fmt.cause = CAUSE_MISALIGN;
      end
      default: begin
        fmt.be    = '0;
        fmt.cause = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Stage, outstanding count and bus-error report next-state.
  always_comb begin
    stage_d = stage_q;
    if (accept) begin
      stage_d = fmt;
    end else if (stage_done) begin
      stage_d.valid = 1'b0;
    end
    case ({issue, rsp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    buserr_d      = rsp_fire && dc_rsp_err_i;
    buserr_addr_d = buserr_d ? fifo_head : '0;
  end

  // Fault output mux: bus error from the previous cycle outranks the stage.
  always_comb begin
    fault_valid_o = buserr_q || stage_fault;
    fault_cause_o = CAUSE_NONE;
    fault_addr_o  = '0;
    if (buserr_q) begin
      fault_cause_o = CAUSE_BUSERR;
      fault_addr_o  = buserr_addr_q;
    end else if (stage_fault) begin
      fault_cause_o = stage_q.cause;
      fault_addr_o  = stage_q.addr;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q       <= '0;
      cnt_q         <= '0;
      buserr_q      <= 1'b0;
      buserr_addr_q <= '0;
    end else begin
      stage_q       <= stage_d;
      cnt_q         <= cnt_d;
      buserr_q      <= buserr_d;
      buserr_addr_q <= buserr_addr_d;
    end
  end

  sdu_addr_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (SDU_PLEN)
  ) u_addr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .data_i  (stage_q.addr),
    .pop_i   (rsp_fire),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_stray_ack: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dc_rsp_valid_i && (cnt_q == '0)))
    else $error("write ack received with no write outstanding");

  a_fifo_tracks_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
    (fifo_empty == (cnt_q == '0)) && (fifo_full == (cnt_q == CNT_W'(OUTSTANDING))))
    else $error("address FIFO occupancy diverged from outstanding count");

endmodule

// File: tb/tb_store_drain_unit.sv
// Self-checking bench for store_drain_unit: vector table, corner sequences, random.
module tb_store_drain_unit;
  import decode_pkg::*;
  import store_drain_unit_pkg::*;

  localparam int OUTS = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        sb_req_valid_i = 1'b0;
  logic        sb_req_ready_o;
  logic [31:0] sb_req_addr_i = '0;
  logic [31:0] sb_req_data_i = '0;
  lsu_op_e     sb_req_op_i = LSU_SW;
  logic        dc_req_valid_o;
  logic        dc_req_ready_i = 1'b1;
  logic [31:0] dc_req_addr_o;
  logic [31:0] dc_req_wdata_o;
  logic [3:0]  dc_req_be_o;
  logic        dc_rsp_valid_i = 1'b0;
  logic        dc_rsp_err_i = 1'b0;
  logic        fault_valid_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] fault_addr_o;
  logic        idle_o;

  store_drain_unit #(.OUTSTANDING(OUTS)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sb_req_valid_i (sb_req_valid_i),
    .sb_req_ready_o (sb_req_ready_o),
    .sb_req_addr_i  (sb_req_addr_i),
    .sb_req_data_i  (sb_req_data_i),
    .sb_req_op_i    (sb_req_op_i),
    .dc_req_valid_o (dc_req_valid_o),
    .dc_req_ready_i (dc_req_ready_i),
    .dc_req_addr_o  (dc_req_addr_o),
    .dc_req_wdata_o (dc_req_wdata_o),
    .dc_req_be_o    (dc_req_be_o),
    .dc_rsp_valid_i (dc_rsp_valid_i),
    .dc_rsp_err_i   (dc_rsp_err_i),
    .fault_valid_o  (fault_valid_o),
    .fault_cause_o  (fault_cause_o),
    .fault_addr_o   (fault_addr_o),
    .idle_o         (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input lsu_op_e op);
    sb_req_valid_i = 1'b1;
    sb_req_addr_i  = a;
    sb_req_data_i  = d;
    sb_req_op_i    = op;
  endtask

  // Reference formatting by byte lanes: a store of 'size' bytes at offset 'off'
  // covers lanes off..off+size-1, and lane i carries data byte (i mod size).
  function automatic void ref_fmt(input logic [31:0] a, input logic [31:0] d, input lsu_op_e op,
                                  output logic [31:0] wd, output logic [3:0] be,
                                  output logic [1:0] cause);
    int size;
    int off;
    off = int'(a % 4);
    case (op)
      LSU_SB:  size = 1;
      LSU_SH:  size = 2;
      LSU_SW:  size = 4;
      default: size = 0;
    endcase
    wd = '0;
    be = '0;
    if (size == 0) cause = 2'd3;
    else if (off % size != 0) cause = 2'd1;
    else cause = 2'd0;
    if (size != 0) begin
      for (int i = 0; i < 4; i++) begin
        be[i] = (i >= off) && (i < off + size);
        wd[8*i +: 8] = d[8*(i % size) +: 8];
      end
    end
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    lsu_op_e     op;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [1:0]  exp_cause;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  cause;
  } flt_t;

  vec_t        vecs[9];
  wr_t         exp_wr_q[$];
  flt_t        flt_q[$];
  logic [31:0] iss_q[$];

  initial begin
    int          nis;
    int          pending;
    int          outs;
    logic        exp_be_pend;
    logic [31:0] exp_be_addr;
    logic        acc_last;
    logic        issue_now;
    logic        acc_now;
    logic        rsp_now;
    logic        err_now;
    logic [31:0] ra;
    logic [31:0] rd;
    lsu_op_e     rop;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    logic [1:0]  m_cause;
    wr_t         w;
    flt_t        f;
    int          r;

    vecs[0] = '{32'h8000_0003, 32'h0000_00AB, LSU_SB, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 2'd0};
    vecs[1] = '{32'h0000_1002, 32'h0000_1234, LSU_SH, 32'h0000_1000, 32'h1234_1234, 4'b1100, 2'd0};
    vecs[2] = '{32'h0000_1001, 32'h0000_1234, LSU_SH, 32'h0000_1001, 32'h0,         4'b0000, 2'd1};
    vecs[3] = '{32'h0000_2000, 32'hDEAD_BEEF, LSU_SW, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 2'd0};
    vecs[4] = '{32'h0000_2002, 32'hDEAD_BEEF, LSU_SW, 32'h0000_2002, 32'h0,         4'b0000, 2'd1};
    vecs[5] = '{32'h0000_0010, 32'h0000_1FF5, LSU_SB, 32'h0000_0010, 32'hF5F5_F5F5, 4'b0001, 2'd0};
    vecs[6] = '{32'h0000_0020, 32'hFFFF_5678, LSU_SH, 32'h0000_0020, 32'h5678_5678, 4'b0011, 2'd0};
    vecs[7] = '{32'h0000_0040, 32'h1111_2222, LSU_LW, 32'h0000_0040, 32'h0,         4'b0000, 2'd3};
    vecs[8] = '{32'h0000_0041, 32'h0000_007C, LSU_SB, 32'h0000_0040, 32'h7C7C_7C7C, 4'b0010, 2'd0};

    // ---------------- reset values ----------------
    #1 rst_i = 1'b1;
    #1;
    chk("rst_ready", sb_req_ready_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_dc_valid", dc_req_valid_o, 1'b0);
    chk("rst_fault", fault_valid_o, 1'b0);
    chk("rst_dc_be", dc_req_be_o, 4'h0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", sb_req_ready_o, 1'b1);
    chk("post_rst_idle", idle_o, 1'b1);

    // ---------------- vector table ----------------
    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      drive_req(vecs[i].addr, vecs[i].data, vecs[i].op);
      dc_req_ready_i = 1'b1;
      #1;
      chk("tbl_ready", sb_req_ready_o, 1'b1);
      @(negedge clk_i);
      sb_req_valid_i = 1'b0;
      #1;
      if (vecs[i].exp_cause == 2'd0) begin
        chk("tbl_dc_valid", dc_req_valid_o, 1'b1);
        chk("tbl_dc_addr", dc_req_addr_o, vecs[i].exp_addr);
        chk("tbl_dc_wdata", dc_req_wdata_o, vecs[i].exp_wdata);
        chk("tbl_dc_be", dc_req_be_o, vecs[i].exp_be);
        chk("tbl_no_fault", fault_valid_o, 1'b0);
        @(negedge clk_i);
        dc_rsp_valid_i = 1'b1;
        #1;
        chk("tbl_busy", idle_o, 1'b0);
        @(negedge clk_i);
        dc_rsp_valid_i = 1'b0;
        #1;
        chk("tbl_idle_after_ack", idle_o, 1'b1);
      end else begin
        chk("tbl_no_dc", dc_req_valid_o, 1'b0);
        chk("tbl_fault", fault_valid_o, 1'b1);
        chk("tbl_fault_cause", fault_cause_o, vecs[i].exp_cause);
        chk("tbl_fault_addr", fault_addr_o, vecs[i].exp_addr);
        @(negedge clk_i);
        #1;
        chk("tbl_fault_pulse_end", fault_valid_o, 1'b0);
        chk("tbl_fault_idle", idle_o, 1'b1);
      end
    end

    // ---------------- three SWs back-to-back, acks withheld ----------------
    @(negedge clk_i);
    drive_req(32'h3000, 32'h1111_1111, LSU_SW);
    #1;
    chk("bb_acc0", sb_req_ready_o, 1'b1);
    @(negedge clk_i);
    drive_req(32'h3004, 32'h2222_2222, LSU_SW);
    #1;
    chk("bb_iss0", {dc_req_valid_o, dc_req_addr_o}, {1'b1, 32'h3000});
    chk("bb_acc1", sb_req_ready_o, 1'b1);
    @(negedge clk_i);
    drive_req(32'h3008, 32'h3333_3333, LSU_SW);
    #1;
    chk("bb_iss1", {dc_req_valid_o, dc_req_addr_o}, {1'b1, 32'h3004});
    chk("bb_acc2", sb_req_ready_o, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      sb_req_valid_i = 1'b0;
      #1;
      chk("bb_held_valid", dc_req_valid_o, 1'b0);
      chk("bb_held_ready", sb_req_ready_o, 1'b0);
    end
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b1;
    #1;
    chk("bb_release", {dc_req_valid_o, dc_req_addr_o}, {1'b1, 32'h3008});
    chk("bb_release_ready", sb_req_ready_o, 1'b1);
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b0;
    #1;
    chk("bb_after_release", {dc_req_valid_o, idle_o}, 2'b00);
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b0;
    #1;
    chk("bb_one_left", idle_o, 1'b0);
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b0;
    #1;
    chk("bb_drained", idle_o, 1'b1);

    // ---------------- D-cache back-pressure for 5 cycles ----------------
    @(negedge clk_i);
    dc_req_ready_i = 1'b0;
    drive_req(32'h4000, 32'hCAFE_F00D, LSU_SW);
    #1;
    chk("bp_acc", sb_req_ready_o, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      sb_req_valid_i = 1'b0;
      #1;
      chk("bp_stable_hdr", {dc_req_valid_o, dc_req_be_o, dc_req_addr_o}, {1'b1, 4'hF, 32'h4000});
      chk("bp_stable_wdata", dc_req_wdata_o, 32'hCAFE_F00D);
    end
    nis = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      dc_req_ready_i = 1'b1;
      #1;
      if (dc_req_valid_o && dc_req_ready_i) nis++;
    end
    chk("bp_one_issue", nis, 1);
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b0;
    #1;
    chk("bp_idle", idle_o, 1'b1);

    // ---------------- bus error on 2nd ack vs misaligned stage ----------------
    @(negedge clk_i);
    drive_req(32'h5000, 32'hAAAA_0000, LSU_SW);
    @(negedge clk_i);
    drive_req(32'h5004, 32'hBBBB_0000, LSU_SW);
    #1;
    chk("be_iss0", {dc_req_valid_o, dc_req_addr_o}, {1'b1, 32'h5000});
    @(negedge clk_i);
    sb_req_valid_i = 1'b0;
    #1;
    chk("be_iss1", {dc_req_valid_o, dc_req_addr_o}, {1'b1, 32'h5004});
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b1;
    dc_rsp_err_i   = 1'b0;
    @(negedge clk_i);
    dc_rsp_err_i = 1'b1;
    drive_req(32'h5006, 32'hCCCC_0000, LSU_SW);
    #1;
    chk("be_mis_acc", sb_req_ready_o, 1'b1);
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b0;
    dc_rsp_err_i   = 1'b0;
    sb_req_valid_i = 1'b0;
    #1;
    chk("be_fault", {fault_valid_o, fault_cause_o}, {1'b1, 2'd2});
    chk("be_fault_addr", fault_addr_o, 32'h5004);
    chk("be_stage_wait_ready", sb_req_ready_o, 1'b0);
    chk("be_no_dc", dc_req_valid_o, 1'b0);
    @(negedge clk_i);
    #1;
    chk("be_mis_fault", {fault_valid_o, fault_cause_o}, {1'b1, 2'd1});
    chk("be_mis_addr", fault_addr_o, 32'h5006);
    chk("be_mis_ready", sb_req_ready_o, 1'b1);
    @(negedge clk_i);
    #1;
    chk("be_quiet", {fault_valid_o, idle_o}, 2'b01);

    // ---------------- reset with two writes outstanding ----------------
    @(negedge clk_i);
    drive_req(32'h6000, 32'h1, LSU_SW);
    @(negedge clk_i);
    drive_req(32'h6004, 32'h2, LSU_SW);
    @(negedge clk_i);
    sb_req_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rr_busy", {idle_o, dc_req_valid_o}, 2'b00);
    @(negedge clk_i);
    rst_i = 1'b1;
    dc_rsp_valid_i = 1'b1;
    #1;
    chk("rr_idle", idle_o, 1'b1);
    chk("rr_ready", sb_req_ready_o, 1'b0);
    chk("rr_outs", {dc_req_valid_o, fault_valid_o}, 2'b00);
    @(negedge clk_i);
    #1;
    chk("rr_idle_hold", idle_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b0;
    dc_rsp_valid_i = 1'b0;
    #1;
    chk("rr_release_ready", sb_req_ready_o, 1'b1);
    chk("rr_release_idle", idle_o, 1'b1);
    @(negedge clk_i);
    drive_req(32'h6008, 32'h3, LSU_SW);
    @(negedge clk_i);
    sb_req_valid_i = 1'b0;
    #1;
    chk("rr_fresh_issue", {dc_req_valid_o, dc_req_addr_o}, {1'b1, 32'h6008});
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    dc_rsp_valid_i = 1'b0;
    #1;
    chk("rr_fresh_idle", idle_o, 1'b1);

    // ---------------- randomized traffic against a transaction model ----------------
    pending     = 0;
    outs        = 0;
    exp_be_pend = 1'b0;
    exp_be_addr = '0;
    acc_last    = 1'b0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      @(negedge clk_i);
      if (!sb_req_valid_i || acc_last) begin
        if (cyc < 3000 && ($urandom % 4 != 0)) begin
          r  = int'($urandom % 10);
          ra = $urandom;
          rd = $urandom;
          if (r < 3) rop = LSU_SB;
          else if (r < 6) rop = LSU_SH;
          else if (r < 9) rop = LSU_SW;
          else rop = LSU_LW;
          if (rop == LSU_SH && ($urandom % 4 != 0)) ra[0] = 1'b0;
          if (rop == LSU_SW && ($urandom % 4 != 0)) ra[1:0] = 2'b00;
          drive_req(ra, rd, rop);
        end else begin
          sb_req_valid_i = 1'b0;
        end
      end
      if (cyc >= 3000) sb_req_valid_i = 1'b0;
      dc_req_ready_i = (cyc >= 3000) ? 1'b1 : ($urandom % 4 != 0);
      dc_rsp_valid_i = (outs > 0) && ($urandom % 3 != 0);
      dc_rsp_err_i   = dc_rsp_valid_i && ($urandom % 5 == 0);
      #1;

      chk("rnd_idle", idle_o, (pending == 0) && (outs == 0));

      if (exp_be_pend) begin
        chk("rnd_buserr", {fault_valid_o, fault_cause_o}, {1'b1, 2'd2});
        chk("rnd_buserr_addr", fault_addr_o, exp_be_addr);
      end else if (fault_valid_o) begin
        if (flt_q.size() == 0) begin
          chk("rnd_fault_unexp", fault_valid_o, 1'b0);
        end else begin
          f = flt_q.pop_front();
          chk("rnd_fault_cause", fault_cause_o, f.cause);
          chk("rnd_fault_addr", fault_addr_o, f.addr);
          pending--;
        end
      end

      issue_now = dc_req_valid_o && dc_req_ready_i;
      acc_now   = sb_req_valid_i && sb_req_ready_o;
      rsp_now   = dc_rsp_valid_i;
      err_now   = dc_rsp_err_i;

      if (issue_now) begin
        chk("rnd_limit", (outs < OUTS) || rsp_now, 1'b1);
        if (exp_wr_q.size() == 0) begin
          chk("rnd_issue_unexp", dc_req_valid_o, 1'b0);
        end else begin
          w = exp_wr_q.pop_front();
          chk("rnd_wr_addr", dc_req_addr_o, {w.addr[31:2], 2'b00});
          chk("rnd_wr_data", dc_req_wdata_o, w.wdata);
          chk("rnd_wr_be", dc_req_be_o, w.be);
          iss_q.push_back(w.addr);
          pending--;
        end
      end

      if (rsp_now && iss_q.size() > 0) begin
        exp_be_addr = iss_q.pop_front();
        exp_be_pend = err_now;
        outs--;
      end else begin
        exp_be_pend = 1'b0;
      end
      if (issue_now) outs++;

      if (acc_now) begin
        chk("rnd_accept_free", pending, 0);
        ref_fmt(sb_req_addr_i, sb_req_data_i, sb_req_op_i, m_wd, m_be, m_cause);
        if (m_cause == 2'd0) exp_wr_q.push_back('{sb_req_addr_i, m_wd, m_be});
        else flt_q.push_back('{sb_req_addr_i, m_cause});
        pending++;
      end
      acc_last = acc_now;
    end
    chk("rnd_drain", pending + outs + exp_wr_q.size() + flt_q.size() + int'(exp_be_pend), 0);
    chk("rnd_final_idle", idle_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
